seq_modn_detector: RTL
======================

# seq_modn_detector

Streaming divisibility detector: consumes an MSB-first binary number DW bits per accepted beat and flags, one cycle later, every beat after which the number received so far is an exact multiple of MOD. It is the parametrised successor of the fixed 1-bit, modulus-3 serial detector, adding a configurable modulus and beat width, a valid qualifier, a synchronous restart and an exposed running remainder. It sits on serial or narrow-parallel data paths as a checksum-style qualifier.

## Interface
- MOD, 3, modulus; legal range 2..65535.
- DW, 1, bits consumed per accepted beat; legal range 1..8.
- RW, $clog2(MOD) (localparam, not overridable), remainder width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat qualifier; data is consumed only when high.
- data  in  DW  beat payload; data[DW-1] is the most significant (earliest) bit.
- clear  in  1  synchronous restart of the number.
- success  out  1  registered; high for one cycle per qualifying beat.
- remainder  out  RW  registered; running value mod MOD.
- hit_cnt  out  16  registered count of success pulses (macro-dependent, see Configuration).

## Operation
- State: rem (RW bits), equal to the value of all bits accepted since reset/clear, mod MOD; always < MOD.
- Update per accepted beat, base value b = rem (or 0 when clear=1): iterate i = DW-1 down to 0: r = 2*r + data[i]; if r >= MOD then r = r - MOD. Start r = b. Intermediate width RW+1 bits; no overflow; single-cycle combinational.
- Cycle priority, evaluated at each rising edge:
  - clear=1, in_valid=0: rem <= 0, success <= 0.
  - clear=1, in_valid=1: restart with this beat: rem <= f(0, data), success <= (f(0, data) == 0).
  - clear=0, in_valid=1: rem <= f(rem, data), success <= (f(rem, data) == 0).
  - clear=0, in_valid=0: rem holds, success <= 0.
- An all-zero beat on rem=0 is a multiple (0 mod MOD) and produces success.
- After reset or clear with no beat accepted, success is 0 even though rem=0.
- remainder output = rem register.
- Out-of-range parameters: elaboration-time $error.

## Timing
- Reset values: success=0, remainder=0, hit_cnt=0. Reset asserted mid-stream discards all state immediately (asynchronous); the first beat after release starts a new number.
- Latency: success and remainder reflect the beat accepted at edge N from edge N (visible in cycle N+1).
- Throughput: one beat per cycle; back-to-back valid beats each produce their own success decision; no backpressure.
- success is a pulse; it is never held across an idle (in_valid=0) cycle.

## Configuration
- SEQ_MODN_HIT_CNT_EN defined: hit_cnt increments by 1 on every cycle in which success is loaded 1; saturates at 16'hFFFF; cleared by rst_n and by clear (in a clear cycle that also produces success, hit_cnt <= 1).
- Undefined: hit_cnt port still present, tied to 16'd0; no counter flops.

## Test plan
- MOD=3, DW=1: bits 1,1,0,1 back-to-back -> remainder 1,0,0,1; success 0,1,1,0 (one cycle after each beat).
- MOD=5, DW=4: beats 0xA, 0x3, 0x7 -> remainder 0,3,0; success 1,0,1; insert in_valid=0 gap between beats -> success 0 during gap, remainder held.
- MOD=7, DW=2: beats 3,1 (rem 3,6), then clear+in_valid with data 0 -> remainder 0, success 1; clear alone -> remainder 0, success 0.
- MOD=3, DW=1 after reset: in_valid=0 for 5 cycles -> success stays 0; assert rst_n low mid-stream with rem=2 -> remainder and success 0 immediately; next beat 1 -> remainder 1.
- SEQ_MODN_HIT_CNT_EN, MOD=2, DW=1: 20 zero beats -> hit_cnt 20; clear -> 0; force near saturation (65540 zero beats) -> hit_cnt 16'hFFFF. Without macro -> hit_cnt 0 throughout.
- Random: MOD in {2,3,10,255,65535}, DW in {1,3,8}, 10k beats with random in_valid/clear vs. reference model of (value mod MOD).

Source files
------------

// File: rtl/seq_modn_detector.sv
// seq_modn_detector: MSB-first streaming divisibility-by-MOD detector, DW bits per beat.
// Define SEQ_MODN_HIT_CNT_EN to enable the saturating success counter on hit_cnt.
module seq_modn_detector #(
    parameter int MOD = 3,
    parameter int DW  = 1,
    localparam int RW = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] data,
    input  logic          clear,
    output logic          success,
    output logic [RW-1:0] remainder,
    output logic [15:0]   hit_cnt
);

    localparam logic [RW:0] MOD_W = (RW+1)'(MOD);

    if (MOD < 2 || MOD > 65535) begin : g_bad_mod
        $error("seq_modn_detector: MOD=%0d outside 2..65535", MOD);
    end
    if (DW < 1 || DW > 8) begin : g_bad_dw
        $error("seq_modn_detector: DW=%0d outside 1..8", DW);
    end

    // Shift-and-reduce one bit at a time; r < MOD keeps 2*r+bit within RW+1 bits.
    function automatic logic [RW-1:0] modStep(input logic [RW-1:0] base,
                                              input logic [DW-1:0] beat);
        logic [RW:0] r;
        r = {1'b0, base};
        for (int i = DW - 1; i >= 0; i--) begin
            r = {r[RW-1:0], beat[i]};
            if (r >= MOD_W) r = r - MOD_W;
        end
        return r[RW-1:0];
    endfunction

    logic [RW-1:0] rem_q, rem_d;
    logic          success_q, success_d;
    logic [RW-1:0] baseRem;
    logic [RW-1:0] stepRem;

    always_comb begin
        baseRem   = clear ? '0 : rem_q;
        stepRem   = modStep(baseRem, data);
        rem_d     = rem_q;
        success_d = 1'b0;
        if (in_valid) begin
            rem_d     = stepRem;
            success_d = (stepRem == '0);
        end else if (clear) begin
            rem_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            success_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            success_q <= success_d;
        end
    end

    assign success   = success_q;
    assign remainder = rem_q;

`ifdef SEQ_MODN_HIT_CNT_EN
    logic [15:0] hitCnt_q, hitCnt_d;

    // A clear restarts the count, but still counts a success produced in the same cycle.
    always_comb begin
        hitCnt_d = hitCnt_q;
        if (clear) begin
            hitCnt_d = success_d ? 16'd1 : 16'd0;
        end else if (success_d && hitCnt_q != 16'hFFFF) begin
            hitCnt_d = hitCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt_q <= '0;
        end else begin
            hitCnt_q <= hitCnt_d;
        end
    end

    assign hit_cnt = hitCnt_q;
`else
    assign hit_cnt = 16'd0;
`endif

endmodule
